maxpool_stream: RTL and testbench
=================================

Name: maxpool_stream

Overview:
- Downstream stage of the conv2d compute block: consumes its flat output tensor, applies non-overlapping POOL x POOL signed max-pooling per channel, and streams pooled words out over a valid/ready interface.
- Snapshots the tensor on start, so the conv block may recompute while pooling proceeds.
- Sits between the conv2d stage and the next layer's loader or a result FIFO.

Parameters:
- CHANNELS, 1, channels in the incoming tensor (conv OUT_CHANNELS x BATCH_SIZE, flattened channel-major)
- IN_HEIGHT, 2, input feature-map height (conv OUT_HEIGHT)
- IN_WIDTH, 2, input feature-map width (conv OUT_WIDTH)
- POOL, 2, pooling window edge; stride equals POOL
- DATA_WIDTH, 32, signed word width
- OUT_HEIGHT, IN_HEIGHT/POOL (floor), derived; leftover rows ignored
- OUT_WIDTH, IN_WIDTH/POOL (floor), derived; leftover columns ignored

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  pulse; sampled only in IDLE
- in_tensor_flat  in  CHANNELS*IN_HEIGHT*IN_WIDTH*DATA_WIDTH  word i at bits [i*DATA_WIDTH +: DATA_WIDTH]; index = c*IN_HEIGHT*IN_WIDTH + h*IN_WIDTH + w
- busy  out  1  high from the start-accept edge until the final transfer
- out_data  out  DATA_WIDTH  pooled signed word
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accept
- out_last  out  1  qualifies the final word of the tensor
- done  out  1  one-cycle pulse after the final transfer

Behaviour:
- Reset (async): state IDLE, snapshot cleared, window/element counters 0.
  - All outputs (busy, out_data, out_valid, out_last, done) are 0 immediately.
  - Reset mid-operation aborts with no partial output and no done.
- States: IDLE, SCAN, EMIT.
- IDLE:
  - done is 0 except on the cycle right after a final transfer.
  - start=1 at an edge: copy in_tensor_flat into the snapshot, set busy=1, clear counters, go to SCAN.
  - Later changes on in_tensor_flat do not affect results.
- SCAN:
  - One window element per cycle, row-major within the window (kh outer, kw inner).
  - Element index: c*IN_HEIGHT*IN_WIDTH + (oh*POOL+kh)*IN_WIDTH + (ow*POOL+kw).
  - The first element loads the max register; later elements replace it only if strictly greater (signed compare).
  - On the POOL*POOL-th element edge, register the result into out_data, set out_valid=1, set out_last if this is the final output, go to EMIT.
- Latency: out_valid rises POOL*POOL edges after the start-accept edge.
- EMIT:
  - out_data, out_valid and out_last hold stable while out_ready=0. No timeout.
  - Transfer on an edge with out_valid and out_ready both high; out_valid drops on that edge.
  - Non-final transfer: advance (ow, then oh, then c) and return to SCAN.
  - Final transfer: busy=0, done=1 for one cycle, out_last=0, go to IDLE.
- Throughput: one word per POOL*POOL+1 cycles when out_ready is held high.
- Output order: channel-major, then oh, then ow. CHANNELS*OUT_HEIGHT*OUT_WIDTH words per start.
- start while busy is ignored, with no queuing.
- start in the same cycle done is high is accepted.
- No arithmetic growth: max of signed DATA_WIDTH values stays DATA_WIDTH.
- Counters sized with $clog2(max(value,2)).
- Degenerate OUT_HEIGHT=0 or OUT_WIDTH=0 is not supported; it is an elaboration-time error.

Optional Feature:
- Macro: MAXPOOL_RELU_EN.
- Defined: ReLU is fused on the output. If the window max is negative, out_data is 0. The comparison still uses raw signed values. Timing is unchanged.
- Undefined: out_data is the raw signed window max.

Test Plan:
- CHANNELS=1, 2x2, POOL=2, tensor [3,-7,12,5], start, out_ready=1 -> out_valid after 4 edges, out_data=12, out_last=1; transfer; done pulses 1 cycle; busy=0.
- Tensor [-4,-2,-9,-3] -> out_data=-2 (0xFFFFFFFE) without MAXPOOL_RELU_EN; 0 with it.
- Backpressure on the first case: out_ready=0 for 10 cycles -> out_valid=1, out_data=12, out_last held stable; transfer only on the edge where out_ready rises.
- CHANNELS=2, 4x4, POOL=2, ch0 = 0..15, ch1 = 0..-15 (ch1[i] = -i) -> 8 words in order [5,7,13,15,0,-2,-8,-10]; out_last high only on the 8th; done once.
- start pulsed during SCAN and during EMIT, and in_tensor_flat changed after acceptance -> results match the snapshot; no restart. A second start on the done cycle begins a new pass.
- rst asserted mid-SCAN of the CHANNELS=2 case -> all outputs 0 immediately, no done. A subsequent start produces the full correct 8-word sequence.

Source files
------------

// File: rtl/maxpool_stream.sv
// maxpool_stream
//   Streaming POOL x POOL signed max-pool stage placed after the conv2d block.
//   The incoming flat tensor is snapshotted when start is accepted, so the
//   producer is free to recompute while pooling runs. Each window is scanned
//   one element per cycle, then the pooled word is offered on a valid/ready
//   port. Output order is channel-major, then output row, then output column.
//
// Build option:
//   MAXPOOL_RELU_EN  - when defined, a negative window max is emitted as 0
//                      (the compare itself still uses raw signed values).
//
// Ports:
//   clk             clock
//   rst             asynchronous, active-high reset
//   start           pulse, sampled only while idle
//   in_tensor_flat  CHANNELS*IN_HEIGHT*IN_WIDTH words, word i at [i*DATA_WIDTH +: DATA_WIDTH]
//   busy            high from start acceptance until the final transfer
//   out_data        pooled signed word
//   out_valid       out_data valid
//   out_ready       downstream accept
//   out_last        marks the final word of the tensor
//   done            one-cycle pulse after the final transfer
//
// state | meaning
// IDLE  | waiting for start; snapshot and counters are don't-care
// SCAN  | reading one window element per cycle into the running max
// EMIT  | pooled word presented, holding until out_ready

module maxpool_stream #(
    parameter int CHANNELS   = 1,
    parameter int IN_HEIGHT  = 2,
    parameter int IN_WIDTH   = 2,
    parameter int POOL       = 2,
    parameter int DATA_WIDTH = 32
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          start,
    input  logic [CHANNELS*IN_HEIGHT*IN_WIDTH*DATA_WIDTH-1:0] in_tensor_flat,
    output logic                                          busy,
    output logic [DATA_WIDTH-1:0]                         out_data,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic                                          out_last,
    output logic                                          done
);

    localparam int OUT_HEIGHT = IN_HEIGHT / POOL;
    localparam int OUT_WIDTH  = IN_WIDTH / POOL;
    localparam int NUM_IN     = CHANNELS * IN_HEIGHT * IN_WIDTH;

    localparam int C_W   = $clog2(CHANNELS   < 2 ? 2 : CHANNELS);
    localparam int OH_W  = $clog2(OUT_HEIGHT < 2 ? 2 : OUT_HEIGHT);
    localparam int OW_W  = $clog2(OUT_WIDTH  < 2 ? 2 : OUT_WIDTH);
    localparam int K_W   = $clog2(POOL       < 2 ? 2 : POOL);
    localparam int IDX_W = $clog2(NUM_IN     < 2 ? 2 : NUM_IN);

    localparam logic [C_W-1:0]  C_LAST  = C_W'(CHANNELS - 1);
    localparam logic [OH_W-1:0] OH_LAST = OH_W'(OUT_HEIGHT - 1);
    localparam logic [OW_W-1:0] OW_LAST = OW_W'(OUT_WIDTH - 1);
    localparam logic [K_W-1:0]  K_LAST  = K_W'(POOL - 1);

    if (OUT_HEIGHT < 1 || OUT_WIDTH < 1) begin : g_bad_geometry
        $error("maxpool_stream: POOL larger than the input map gives an empty output");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic signed [DATA_WIDTH-1:0] snap_q [NUM_IN];
    logic signed [DATA_WIDTH-1:0] max_q;
    logic [C_W-1:0]  c_q;
    logic [OH_W-1:0] oh_q;
    logic [OW_W-1:0] ow_q;
    logic [K_W-1:0]  kh_q;
    logic [K_W-1:0]  kw_q;

    int                           idx_int;
    logic [IDX_W-1:0]             elem_idx;
    logic signed [DATA_WIDTH-1:0] elem;
    logic signed [DATA_WIDTH-1:0] cand;
    logic signed [DATA_WIDTH-1:0] result;
    logic                         win_first;
    logic                         win_end;
    logic                         final_win;
    logic                         xfer;

    always_comb begin
        idx_int   = int'(c_q) * IN_HEIGHT * IN_WIDTH
                  + (int'(oh_q) * POOL + int'(kh_q)) * IN_WIDTH
                  + int'(ow_q) * POOL + int'(kw_q);
        elem_idx  = IDX_W'(idx_int);
        elem      = snap_q[elem_idx];
        win_first = (kh_q == '0) && (kw_q == '0);
        win_end   = (kh_q == K_LAST) && (kw_q == K_LAST);
        final_win = (c_q == C_LAST) && (oh_q == OH_LAST) && (ow_q == OW_LAST);
        xfer      = out_valid && out_ready;
        // The first element seeds the max; later ones only win when strictly greater.
        if (win_first || (elem > max_q)) begin
            cand = elem;
        end else begin
            cand = max_q;
        end
`ifdef MAXPOOL_RELU_EN
        result = cand[DATA_WIDTH-1] ? '0 : cand;
`else
        result = cand;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start)   state_d = SCAN;
            SCAN: if (win_end) state_d = EMIT;
            EMIT: if (xfer)    state_d = out_last ? IDLE : SCAN;
            default:           state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_IN; i++) begin
                snap_q[i] <= '0;
            end
            max_q     <= '0;
            c_q       <= '0;
            oh_q      <= '0;
            ow_q      <= '0;
            kh_q      <= '0;
            kw_q      <= '0;
            busy      <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < NUM_IN; i++) begin
                            snap_q[i] <= in_tensor_flat[i*DATA_WIDTH +: DATA_WIDTH];
                        end
                        busy <= 1'b1;
                        c_q  <= '0;
                        oh_q <= '0;
                        ow_q <= '0;
                        kh_q <= '0;
                        kw_q <= '0;
                    end
                end
                SCAN: begin
                    max_q <= cand;
                    if (win_end) begin
                        kh_q      <= '0;
                        kw_q      <= '0;
                        out_data  <= result;
                        out_valid <= 1'b1;
                        out_last  <= final_win;
                    end else if (kw_q == K_LAST) begin
                        kw_q <= '0;
                        kh_q <= kh_q + 1'b1;
                    end else begin
                        kw_q <= kw_q + 1'b1;
                    end
                end
                EMIT: begin
                    if (xfer) begin
                        out_valid <= 1'b0;
                        if (out_last) begin
                            out_last <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end else if (ow_q == OW_LAST) begin
                            ow_q <= '0;
                            if (oh_q == OH_LAST) begin
                                oh_q <= '0;
                                c_q  <= c_q + 1'b1;
                            end else begin
                                oh_q <= oh_q + 1'b1;
                            end
                        end else begin
                            ow_q <= ow_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_maxpool_stream.sv
// tb_maxpool_stream
//   Directed bench for maxpool_stream. Two instances: a 1-channel 2x2 map
//   (single window) and a 2-channel 4x4 map (eight output words). Inputs are
//   driven and outputs sampled on the falling edge of clk.
//   Honors MAXPOOL_RELU_EN for the expected values of negative windows.

module tb_maxpool_stream;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // small instance: CHANNELS=1, 2x2
    logic         start_s = 1'b0;
    logic [127:0] tensor_s = '0;
    logic         busy_s, valid_s, last_s, done_s;
    logic [31:0]  data_s;
    logic         ready_s = 1'b0;

    // big instance: CHANNELS=2, 4x4
    logic          start_b = 1'b0;
    logic [1023:0] tensor_b = '0;
    logic          busy_b, valid_b, last_b, done_b;
    logic [31:0]   data_b;
    logic          ready_b = 1'b0;

    maxpool_stream #(
        .CHANNELS(1), .IN_HEIGHT(2), .IN_WIDTH(2), .POOL(2), .DATA_WIDTH(32)
    ) u_small (
        .clk(clk), .rst(rst), .start(start_s), .in_tensor_flat(tensor_s),
        .busy(busy_s), .out_data(data_s), .out_valid(valid_s),
        .out_ready(ready_s), .out_last(last_s), .done(done_s)
    );

    maxpool_stream #(
        .CHANNELS(2), .IN_HEIGHT(4), .IN_WIDTH(4), .POOL(2), .DATA_WIDTH(32)
    ) u_big (
        .clk(clk), .rst(rst), .start(start_b), .in_tensor_flat(tensor_b),
        .busy(busy_b), .out_data(data_b), .out_valid(valid_b),
        .out_ready(ready_b), .out_last(last_b), .done(done_b)
    );

    localparam int BIG_EXP [8] = '{5, 7, 13, 15, 0, -2, -8, -10};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] relu(input logic [31:0] v);
`ifdef MAXPOOL_RELU_EN
        return v[31] ? 32'd0 : v;
`else
        return v;
`endif
    endfunction

    function automatic logic [127:0] pack4(input int a, input int b, input int c, input int d);
        return {32'(d), 32'(c), 32'(b), 32'(a)};
    endfunction

    // Returns on the falling edge right after the accepting rising edge.
    task automatic start_small(input logic [127:0] t);
        @(negedge clk);
        tensor_s = t;
        start_s  = 1'b1;
        @(negedge clk);
        start_s  = 1'b0;
    endtask

    task automatic wait_valid_s(input string tag, input int exp_lat);
        int n = 0;
        while (!valid_s && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(tag, n, exp_lat);
    endtask

    task automatic run_big(input string tag);
        int n     = 0;
        int dones = 0;
        int cyc   = 0;
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        while (n < 8 && cyc < 300) begin
            ready_b = (cyc % 3) != 1;
            if (valid_b && ready_b) begin
                check($sformatf("%s_word%0d", tag, n), data_b, relu(BIG_EXP[n]));
                check($sformatf("%s_last%0d", tag, n), {31'd0, last_b}, {31'd0, n == 7});
                n++;
            end
            @(negedge clk);
            cyc++;
            if (done_b) dones++;
        end
        repeat (3) begin
            @(negedge clk);
            if (done_b) dones++;
        end
        check({tag, "_count"}, n, 8);
        check({tag, "_dones"}, dones, 1);
        check({tag, "_idle"}, {30'd0, busy_b, valid_b}, 32'd0);
    endtask

    initial begin
        int stable;
        int bad;
        for (int i = 0; i < 16; i++) begin
            tensor_b[i*32 +: 32]      = 32'(i);
            tensor_b[(16+i)*32 +: 32] = 32'(-i);
        end

        #1;
        check("rst_small_flags", {28'd0, busy_s, valid_s, last_s, done_s}, 32'd0);
        check("rst_small_data", data_s, 32'd0);
        check("rst_big_flags", {28'd0, busy_b, valid_b, last_b, done_b}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // basic window, ready held high
        ready_s = 1'b1;
        start_small(pack4(3, -7, 12, 5));
        check("t1_busy", {31'd0, busy_s}, 32'd1);
        wait_valid_s("t1_latency", 4);
        check("t1_data", data_s, 32'd12);
        check("t1_last", {31'd0, last_s}, 32'd1);
        @(negedge clk);
        check("t1_after_xfer", {28'd0, busy_s, valid_s, last_s, done_s}, 32'd1);
        @(negedge clk);
        check("t1_done_once", {31'd0, done_s}, 32'd0);

        // all-negative window
        start_small(pack4(-4, -2, -9, -3));
        wait_valid_s("t2_latency", 4);
        check("t2_data", data_s, relu(32'hFFFF_FFFE));
        @(negedge clk);
        check("t2_done", {31'd0, done_s}, 32'd1);

        // backpressure: output holds for 10 cycles
        ready_s = 1'b0;
        start_small(pack4(3, -7, 12, 5));
        wait_valid_s("t3_latency", 4);
        stable = 0;
        repeat (10) begin
            @(negedge clk);
            if (valid_s && data_s == 32'd12 && last_s && !done_s) stable++;
        end
        check("t3_hold", stable, 10);
        ready_s = 1'b1;
        @(negedge clk);
        check("t3_xfer", {30'd0, valid_s, done_s}, 32'd1);

        // start ignored in SCAN and EMIT, tensor changes ignored
        ready_s = 1'b0;
        start_small(pack4(3, -7, 12, 5));
        @(negedge clk);
        start_s  = 1'b1;
        tensor_s = pack4(100, 100, 100, 100);
        @(negedge clk);
        start_s  = 1'b0;
        wait_valid_s("t4_no_restart", 2);
        check("t4_data", data_s, 32'd12);
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        check("t4_emit_hold", {valid_s, data_s[30:0]}, {1'b1, 31'd12});
        ready_s = 1'b1;
        @(negedge clk);
        check("t4_done", {31'd0, done_s}, 32'd1);
        // start on the done cycle begins a new pass
        start_s  = 1'b1;
        tensor_s = pack4(1, 2, 3, 4);
        @(negedge clk);
        start_s  = 1'b0;
        check("t4_restart_busy", {31'd0, busy_s}, 32'd1);
        wait_valid_s("t4_restart_latency", 4);
        check("t4_restart_data", data_s, 32'd4);
        @(negedge clk);
        check("t4_restart_done", {31'd0, done_s}, 32'd1);

        // two channels, 4x4, with mixed backpressure
        run_big("t5");

        // reset mid-SCAN, then a clean full pass
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        @(negedge clk);
        check("t6_busy_pre", {31'd0, busy_b}, 32'd1);
        rst = 1'b1;
        #1;
        check("t6_rst_flags", {28'd0, busy_b, valid_b, last_b, done_b}, 32'd0);
        check("t6_rst_data", data_b, 32'd0);
        bad = 0;
        repeat (2) begin
            @(negedge clk);
            if (valid_b || done_b || busy_b) bad++;
        end
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (valid_b || done_b || busy_b) bad++;
        end
        check("t6_quiet", bad, 0);
        run_big("t7");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
